// File: rtl/wb_bridge_pkg.sv
// Shared types and lane constants for the Wishbone master bridge.
package wb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } wb_size_e;

  localparam logic [3:0] SEL_B = 4'b0001;
  localparam logic [3:0] SEL_H = 4'b0011;
  localparam logic [3:0] SEL_W = 4'b1111;

  // Request as seen on the core side; addr_lo is the byte offset within the word.
  typedef struct packed {
    logic        we;
    logic [1:0]  addr_lo;
    logic [1:0]  size;
    logic        is_unsigned;
    logic [31:0] wdata;
  } wb_req_t;

  // Size encoding 3 is illegal and is reported the same way as a misalignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_B:    return 1'b0;
      SZ_H:    return addr_lo[0];
      SZ_W:    return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/wb_lane_steer.sv
// Combinational byte-lane steering for stores and load extraction/extension.
module wb_lane_steer
  import wb_bridge_pkg::*;
(
  input  logic [1:0]  st_addr_lo_i,
  input  logic [1:0]  st_size_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign misalign_o = is_misaligned(st_size_i, st_addr_lo_i);
  assign shifted    = rdata_i >> {ld_addr_lo_i, 3'b000};

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    sel_o   = '0;
    wdata_o = st_wdata_i;
    case (st_size_i)
      SZ_B: begin
        sel_o   = SEL_B << st_addr_lo_i;
        wdata_o = {4{st_wdata_i[7:0]}};
      end
      SZ_H: begin
        sel_o   = SEL_H << st_addr_lo_i;
        wdata_o = {2{st_wdata_i[15:0]}};
      end
      SZ_W: sel_o = SEL_W;
      default: sel_o = '0;
    endcase
  end

  always_comb begin
    rdata_o = shifted;
    case (ld_size_i)
      SZ_B: rdata_o = ld_unsigned_i ? {24'b0, shifted[7:0]}
                                    : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H: rdata_o = ld_unsigned_i ? {16'b0, shifted[15:0]}
                                    : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_o = shifted;
    endcase
  end

endmodule

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone classic initiator behind a valid/ready load/store port.
// Optional bus timeout: define WB_MASTER_TIMEOUT_EN.
module wb_master_bridge
  import wb_bridge_pkg::*;
#(
  parameter int unsigned AW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TW             = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic          req_we_i,
  input  logic [AW-1:0] req_addr_i,
  input  logic [1:0]    req_size_i,
  input  logic          req_unsigned_i,
  input  logic [31:0]   req_wdata_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [31:0]   wb_dat_o,
  output logic [3:0]    wb_sel_o,
  input  logic [31:0]   wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i
);

  wb_state_e     state_q, state_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]    off_q, off_d;
  logic [1:0]    size_q, size_d;
  logic          uns_q, uns_d;
  logic          load_q, load_d;

  wb_req_t       req_in;
  logic [3:0]    st_sel;
  logic [31:0]   st_wdata;
  logic          st_misalign;
  logic [31:0]   ld_rdata;
  logic          tmo_hit;

  assign req_in = '{we:          req_we_i,
                    addr_lo:     req_addr_i[1:0],
                    size:        req_size_i,
                    is_unsigned: req_unsigned_i,
                    wdata:       req_wdata_i};

  // Store steering follows the incoming request; load extraction follows the latched one.
  wb_lane_steer u_steer (
    .st_addr_lo_i  (req_in.addr_lo),
    .st_size_i     (req_in.size),
    .st_wdata_i    (req_in.wdata),
    .sel_o         (st_sel),
    .wdata_o       (st_wdata),
    .misalign_o    (st_misalign),
    .ld_addr_lo_i  (off_q),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .rdata_i       (wb_dat_i),
    .rdata_o       (ld_rdata)
  );

`ifdef WB_MASTER_TIMEOUT_EN
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == BUS) && (tmo_cnt_q == TMO_LIMIT);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != BUS) begin
      tmo_cnt_d = '0;
    end else if (!wb_ack_i && !wb_err_i && !tmo_hit) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) tmo_cnt_q <= '0;
    else            tmo_cnt_q <= tmo_cnt_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    load_d      = load_q;

    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          off_d  = req_in.addr_lo;
          size_d = req_in.size;
          uns_d  = req_in.is_unsigned;
          load_d = !req_in.we;
          if (st_misalign) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            we_d    = req_in.we;
            adr_d   = {req_addr_i[AW-1:2], 2'b00};
            dat_d   = st_wdata;
            sel_d   = st_sel;
          end
        end
      end

      BUS: begin
        if (wb_err_i || wb_ack_i || tmo_hit) begin
          state_d     = RESP;
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          // err beats ack, and ack beats a timeout landing in the same cycle.
          rsp_err_d   = wb_err_i || !wb_ack_i;
          rsp_rdata_d = (wb_ack_i && !wb_err_i && load_q) ? ld_rdata : '0;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      load_q      <= load_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = sel_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Scoreboard bench for wb_master_bridge: stimulus queues expected responses and bus beats,
// monitors compare them whenever the DUT presents a response or starts a bus cycle.
module tb_wb_master_bridge;
  import wb_bridge_pkg::*;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid_i, req_ready_o, req_we_i, req_unsigned_i;
  logic [AW-1:0] req_addr_i;
  logic [1:0]    req_size_i;
  logic [31:0]   req_wdata_i;
  logic          rsp_valid_o, rsp_ready_i, rsp_err_o;
  logic [31:0]   rsp_rdata_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_adr_o;
  logic [31:0]   wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel_o;
  logic          wb_ack_i, wb_err_i;

  // Slave model: ack after ack_delay cycles of cyc, optional simultaneous err.
  logic          ack_en = 1'b1;
  logic          err_en = 1'b0;
  int unsigned   ack_delay = 0;
  int unsigned   busc = 0;
  logic [31:0]   slave_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  typedef struct { logic [31:0] adr; logic [3:0] sel; logic [31:0] dat; logic we; } beat_t;
  rsp_t  sb_q[$];
  beat_t bus_q[$];

  always #5 clk = ~clk;

  assign wb_ack_i = wb_cyc_o && wb_stb_o && ack_en && (busc >= ack_delay);
  assign wb_err_i = wb_cyc_o && wb_stb_o && err_en;
  assign wb_dat_i = slave_rdata;

  always @(posedge clk) busc <= wb_cyc_o ? busc + 1 : 0;

  wb_master_bridge #(.AW(AW), .TIMEOUT_CYCLES(4), .TW(8)) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (rst_n),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .req_wdata_i    (req_wdata_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every cycle a response is presented it must match the queue head.
  always @(negedge clk) begin
    if (rst_n && rsp_valid_o) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata 0x%08h err %0b with nothing expected",
                 rsp_rdata_o, rsp_err_o);
      end else begin
        check("rsp rdata", rsp_rdata_o, sb_q[0].rdata);
        check("rsp err", rsp_err_o, sb_q[0].err);
        if (rsp_ready_i) void'(sb_q.pop_front());
      end
    end
  end

  // Bus monitor: the first cycle of each Wishbone cycle must match the expected beat.
  logic cyc_prev = 1'b0;
  always @(negedge clk) begin
    beat_t b;
    if (wb_cyc_o && !cyc_prev) begin
      if (bus_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_unexpected: cyc rose at adr 0x%08h with no cycle expected", wb_adr_o);
      end else begin
        b = bus_q.pop_front();
        check("bus adr", wb_adr_o, b.adr);
        check("bus sel", wb_sel_o, b.sel);
        check("bus dat", wb_dat_o, b.dat);
        check("bus we", wb_we_o, b.we);
        check("bus stb", wb_stb_o, 1'b1);
      end
    end
    cyc_prev = wb_cyc_o;
  end

  task automatic run_req(input string name, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [3:0] exp_sel, input logic [31:0] exp_dat,
                         input int exp_lat, input int exp_cyc, input int hold);
    int lat;
    int ncyc;
    @(posedge clk); #1;
    check({name, " req_ready"}, req_ready_o, 1'b1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_addr_i     = addr;
    req_size_i     = size;
    req_unsigned_i = uns;
    req_wdata_i    = wdata;
    sb_q.push_back('{rdata: exp_rdata, err: exp_err});
    if (exp_cyc > 0)
      bus_q.push_back('{adr: {addr[31:2], 2'b00}, sel: exp_sel, dat: exp_dat, we: we});
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    lat  = 0;
    ncyc = 0;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clk);
      if (wb_cyc_o) ncyc++;
      if (rsp_valid_o) begin
        lat = i;
        break;
      end
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " cyc cycles"}, 32'(ncyc), 32'(exp_cyc));
    if (lat == 0) begin
      if (sb_q.size() > 0) void'(sb_q.pop_back());
    end else begin
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      rsp_ready_i = 1'b1;
      @(posedge clk); #1;
      rsp_ready_i = 1'b0;
      check({name, " ready after rsp"}, req_ready_o, 1'b1);
      check({name, " valid after rsp"}, rsp_valid_o, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid_i    = 1'b0;
    req_we_i       = 1'b0;
    req_addr_i     = '0;
    req_size_i     = 2'd0;
    req_unsigned_i = 1'b0;
    req_wdata_i    = '0;
    rsp_ready_i    = 1'b0;
    rst_n          = 1'b0;

    @(negedge clk);
    check("in reset cyc", wb_cyc_o, 1'b0);
    check("in reset rsp_valid", rsp_valid_o, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset req_ready", req_ready_o, 1'b1);
    check("reset cyc", wb_cyc_o, 1'b0);
    check("reset stb", wb_stb_o, 1'b0);
    check("reset we", wb_we_o, 1'b0);
    check("reset adr", wb_adr_o, 32'h0);
    check("reset sel", wb_sel_o, 4'h0);
    check("reset dat", wb_dat_o, 32'h0);
    check("reset rsp_valid", rsp_valid_o, 1'b0);
    check("reset rsp_rdata", rsp_rdata_o, 32'h0);
    check("reset rsp_err", rsp_err_o, 1'b0);

    run_req("st_w", 1'b1, 32'h04, SZ_W, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0,
            4'hF, 32'hDEADBEEF, 2, 1, 0);

    slave_rdata = 32'h80FF_0000;
    run_req("ld_b_s", 1'b0, 32'h07, SZ_B, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0,
            4'h8, 32'h0, 2, 1, 0);
    run_req("ld_b_u", 1'b0, 32'h07, SZ_B, 1'b1, 32'h0, 32'h0000_0080, 1'b0,
            4'h8, 32'h0, 2, 1, 0);

    run_req("st_h_mis", 1'b1, 32'h03, SZ_H, 1'b0, 32'h1234, 32'h0, 1'b1,
            4'h0, 32'h0, 1, 0, 0);
    run_req("st_sz3", 1'b1, 32'h00, 2'd3, 1'b0, 32'h1234, 32'h0, 1'b1,
            4'h0, 32'h0, 1, 0, 0);
    run_req("ld_w_mis", 1'b0, 32'h02, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1,
            4'h0, 32'h0, 1, 0, 0);

    run_req("st_b", 1'b1, 32'h02, SZ_B, 1'b0, 32'h0000_00A5, 32'h0, 1'b0,
            4'h4, 32'hA5A5_A5A5, 2, 1, 0);
    run_req("st_h", 1'b1, 32'h02, SZ_H, 1'b0, 32'h1234_BEEF, 32'h0, 1'b0,
            4'hC, 32'hBEEF_BEEF, 2, 1, 0);

    slave_rdata = 32'h1234_5678;
    run_req("ld_w", 1'b0, 32'h08, SZ_W, 1'b1, 32'h0, 32'h1234_5678, 1'b0,
            4'hF, 32'h0, 2, 1, 0);

    slave_rdata = 32'h1234_8001;
    run_req("ld_h_s0", 1'b0, 32'h00, SZ_H, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0,
            4'h3, 32'h0, 2, 1, 0);

    slave_rdata = 32'h8001_0000;
    ack_delay   = 2;
    run_req("ld_h_dly", 1'b0, 32'h06, SZ_H, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0,
            4'hC, 32'h0, 4, 3, 3);
    run_req("ld_h_u_dly", 1'b0, 32'h06, SZ_H, 1'b1, 32'h0, 32'h0000_8001, 1'b0,
            4'hC, 32'h0, 4, 3, 0);
    ack_delay   = 0;

    slave_rdata = 32'h5555_5555;
    err_en      = 1'b1;
    run_req("ld_ackerr", 1'b0, 32'h10, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1,
            4'hF, 32'h0, 2, 1, 0);
    err_en      = 1'b0;

`ifdef WB_MASTER_TIMEOUT_EN
    ack_en = 1'b0;
    run_req("ld_tmo", 1'b0, 32'h20, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1,
            4'hF, 32'h0, 6, 5, 3);
    ack_en = 1'b1;
`endif

    // Reset while the bus cycle is waiting on a silent slave: no response may appear.
    ack_en = 1'b0;
    @(posedge clk); #1;
    req_valid_i = 1'b1;
    req_we_i    = 1'b0;
    req_addr_i  = 32'h0C;
    req_size_i  = SZ_W;
    bus_q.push_back('{adr: 32'h0C, sel: 4'hF, dat: 32'h0, we: 1'b0});
    @(posedge clk); #1;
    req_valid_i = 1'b0;
    @(posedge clk); #3;
    check("pre-reset cyc", wb_cyc_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async reset cyc", wb_cyc_o, 1'b0);
    check("async reset stb", wb_stb_o, 1'b0);
    check("async reset rsp_valid", rsp_valid_o, 1'b0);
    @(posedge clk); #1;
    rst_n  = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", req_ready_o, 1'b1);
    check("post-reset cyc", wb_cyc_o, 1'b0);

    slave_rdata = 32'hCAFE_F00D;
    run_req("ld_w_after_rst", 1'b0, 32'h0C, SZ_W, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0,
            4'hF, 32'h0, 2, 1, 0);

    repeat (2) @(posedge clk);
    check("responses outstanding", 32'(sb_q.size()), 32'd0);
    check("bus beats outstanding", 32'(bus_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
